hwpf_issue_filter: RTL and testbench

// - Sits between the next-line prefetcher's request output and the HPDcache prefetch request port.
// - Buffers prefetch requests and drops those whose cache line was issued recently.
// - Rate-limits issue and yields to CPU demand traffic, so prefetches never starve or duplicate demand loads.

---
 rtl/hwpf_pkg.sv | 27 ++
 rtl/hwpf_line_filter.sv | 51 +++++
 rtl/hwpf_issue_filter.sv | 169 ++++++++++++++++
 tb/tb_hwpf_issue_filter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpf_pkg.sv
// Shared types for the hardware-prefetch issue filter: request struct, line address, FSM states.
// Line size here is the default; hwpf_issue_filter can override it with its LANE_SIZE parameter.
package hwpf_pkg;

  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned LANE_SIZE_DEFAULT = 64;
  localparam int unsigned LINE_OFS_DEFAULT  = $clog2(LANE_SIZE_DEFAULT);
  localparam int unsigned STAT_W            = 32;

  typedef logic [ADDR_W-1:0]                  addr_t;
  typedef logic [ADDR_W-LINE_OFS_DEFAULT-1:0] line_addr_t;

  typedef struct packed {
    addr_t      addr;
    logic       uncacheable;
    logic [3:0] sid;
    logic [3:0] tid;
    logic       need_rsp;
  } hpdcache_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/hwpf_line_filter.sv
// Small CAM of recently issued cache-line addresses with FIFO replacement.
// Lookup is purely combinational against the registered entries.
module hwpf_line_filter
  import hwpf_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LINE_W = $bits(line_addr_t)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              insert_i,
  input  logic [LINE_W-1:0] insert_line_i,
  input  logic [LINE_W-1:0] lookup_line_i,
  output logic              hit_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LINE_W-1:0] line_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr_q;

  // NOTE: storage arrays carry no reset; the valid bits alone decide whether an entry counts.
  always_ff @(posedge clk_i) begin
    if (insert_i) line_q[wr_ptr_q] <= insert_line_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
    end else if (flush_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
    end else if (insert_i) begin
      valid_q[wr_ptr_q] <= 1'b1;
      wr_ptr_q          <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
  end

  // NOTE: hit_o is given a default before the loop so no latch is inferred.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (line_q[i] == lookup_line_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/hwpf_issue_filter.sv
// Buffers next-line prefetch requests, drops recently issued lines, rate-limits issue and yields to demand.
// Optional HWPF_ISSUE_STATS_EN adds saturating issued/dropped counters.
module hwpf_issue_filter
  import hwpf_pkg::*;
#(
  parameter int unsigned LANE_SIZE    = LANE_SIZE_DEFAULT,
  parameter int unsigned BUF_DEPTH    = 4,
  parameter int unsigned FILTER_DEPTH = 8,
  parameter int unsigned MIN_GAP      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              cpu_demand_i,
  input  logic              pf_req_valid_i,
  output logic              pf_req_ready_o,
  input  hpdcache_req_t     pf_req_i,
  output logic              dcache_req_valid_o,
  input  logic              dcache_req_ready_i,
  output hpdcache_req_t     dcache_req_o,
`ifdef HWPF_ISSUE_STATS_EN
  output logic [STAT_W-1:0] stat_issued_o,
  output logic [STAT_W-1:0] stat_dropped_o,
`endif
  output logic              busy_o
);

  localparam int unsigned LINE_OFS  = $clog2(LANE_SIZE);
  localparam int unsigned LINE_W    = ADDR_W - LINE_OFS;
  localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned GAP_W     = $clog2(MIN_GAP) + 2;
  localparam addr_t       LINE_MASK = ~addr_t'(LANE_SIZE - 1);

  addr_t            buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, push, pop;
  addr_t            head_addr, out_addr_q;
  issue_state_e     state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             load, insert, drop, hit;
  logic             unused_pf_fields;

  assign unused_pf_fields = ^{pf_req_i.uncacheable, pf_req_i.sid, pf_req_i.tid, pf_req_i.need_rsp};

  assign full           = (count_q == CNT_W'(BUF_DEPTH));
  assign empty          = (count_q == '0);
  assign pf_req_ready_o = !full;
  assign push           = pf_req_valid_i && !full && !flush_i;
  assign head_addr      = buf_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) buf_q[wr_ptr_q] <= pf_req_i.addr & LINE_MASK;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  hwpf_line_filter #(
    .DEPTH  (FILTER_DEPTH),
    .LINE_W (LINE_W)
  ) u_line_filter (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .insert_i      (insert),
    .insert_line_i (out_addr_q[ADDR_W-1:LINE_OFS]),
    .lookup_line_i (head_addr[ADDR_W-1:LINE_OFS]),
    .hit_o         (hit)
  );

  // The IDLE decision and REQ cycles count toward the gap, so GAP releases with two cycles left;
  // for MIN_GAP>=3 this spaces handshakes exactly MIN_GAP cycles apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    load    = 1'b0;
    insert  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (hit) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else if (!cpu_demand_i) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dcache_req_ready_i) begin
          insert  = 1'b1;
          gap_d   = GAP_W'(MIN_GAP - 1);
          state_d = (MIN_GAP > 1) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q <= GAP_W'(2)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      out_addr_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (load) out_addr_q <= head_addr;
    end
  end

  always_comb begin
    dcache_req_o      = '0;
    dcache_req_o.addr = out_addr_q;
  end

  assign dcache_req_valid_o = (state_q == REQ);
  assign busy_o             = !empty || (state_q != IDLE);

`ifdef HWPF_ISSUE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_issued_o  <= '0;
      stat_dropped_o <= '0;
    end else if (flush_i) begin
      stat_issued_o  <= '0;
      stat_dropped_o <= '0;
    end else begin
      if (insert && (stat_issued_o != '1))  stat_issued_o  <= stat_issued_o + 1'b1;
      if (drop && (stat_dropped_o != '1))   stat_dropped_o <= stat_dropped_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hwpf_issue_filter.sv
// Directed bench for hwpf_issue_filter: expected issues are queued at push time and
// compared in order against handshakes captured by a negedge monitor.
module tb_hwpf_issue_filter;
  import hwpf_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush, cpu_demand, pf_valid, pf_ready, dc_valid, dc_ready, busy;
  hpdcache_req_t pf_req, dc_req;
`ifdef HWPF_ISSUE_STATS_EN
  logic [STAT_W-1:0] stat_issued, stat_dropped;
`endif

  int    tests = 0;
  int    fails = 0;
  int    cycle = 0;
  int    base, n;
  addr_t exp_q [$];
  addr_t obs_addr [64];
  int    obs_cyc [64];
  int    obs_n  = 0;
  int    rd_idx = 0;

  hwpf_issue_filter dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_i            (flush),
    .cpu_demand_i       (cpu_demand),
    .pf_req_valid_i     (pf_valid),
    .pf_req_ready_o     (pf_ready),
    .pf_req_i           (pf_req),
    .dcache_req_valid_o (dc_valid),
    .dcache_req_ready_i (dc_ready),
    .dcache_req_o       (dc_req),
`ifdef HWPF_ISSUE_STATS_EN
    .stat_issued_o      (stat_issued),
    .stat_dropped_o     (stat_dropped),
`endif
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (rst_n && dc_valid && dc_ready && obs_n < 64) begin
      obs_addr[obs_n] = dc_req.addr;
      obs_cyc[obs_n]  = cycle;
      obs_n           = obs_n + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) cyc();
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic push(input addr_t a, input bit expect_issue);
    int waited;
    waited   = 0;
    pf_valid = 1'b1;
    pf_req.addr = a;
    while (!pf_ready && waited < 50) begin
      cyc();
      waited++;
    end
    check("push_ready", pf_ready, 1'b1);
    if (expect_issue) exp_q.push_back({a[31:6], 6'b0});
    cyc();
    pf_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (rd_idx < obs_n) begin
      if (exp_q.size() == 0) begin
        check({tag, "_extra_issue"}, 32'(obs_n - rd_idx), 32'd0);
        rd_idx = obs_n;
      end else begin
        check({tag, "_addr"}, obs_addr[rd_idx], exp_q.pop_front());
        rd_idx++;
      end
    end
  endtask

  task automatic wait_hs(input string tag, input int budget);
    int target;
    int waited;
    target = rd_idx + exp_q.size();
    waited = 0;
    while (obs_n < target && waited < budget) begin
      cyc();
      waited++;
    end
    check({tag, "_hs_count"}, 32'(obs_n), 32'(target));
    drain(tag);
  endtask

  initial begin
    flush = 1'b0; cpu_demand = 1'b0; pf_valid = 1'b0; pf_req = '0; dc_ready = 1'b0;

    // Reset values
    #12;
    check("rst_valid", dc_valid, 1'b0);
    check("rst_ready", pf_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", dc_req.addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Latency and address stability under back-pressure
    push(32'h0000_1000, 1'b1);
    smp(); check("lat_n1_valid", dc_valid, 1'b0); check("lat_n1_busy", busy, 1'b1);
    cyc(); smp();
    check("lat_n2_valid", dc_valid, 1'b1);
    check("lat_n2_addr", dc_req.addr, 32'h0000_1000);
    check("req_meta", 32'({dc_req.uncacheable, dc_req.sid, dc_req.tid, dc_req.need_rsp}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      check("stall_valid", dc_valid, 1'b1);
      check("stall_addr", dc_req.addr, 32'h0000_1000);
    end
    cyc();
    dc_ready = 1'b1;
    wait_hs("t1", 10);

    // Same-line duplicates are dropped
    flush_pulse();
    push(32'h0000_1004, 1'b1);
    push(32'h0000_1038, 1'b0);
    wait_hs("t2", 20);
    idle(12);
    drain("t2_tail");
    smp(); check("t2_busy", busy, 1'b0);
`ifdef HWPF_ISSUE_STATS_EN
    check("t2_stat_issued", stat_issued, 32'd1);
    check("t2_stat_dropped", stat_dropped, 32'd1);
`endif
    cyc();

    // Rate limiting: handshakes MIN_GAP apart
    flush_pulse();
    base = obs_n;
    push(32'h0000_1000, 1'b1);
    push(32'h0000_1040, 1'b1);
    push(32'h0000_1080, 1'b1);
    wait_hs("t3", 30);
    check("t3_gap01", 32'(obs_cyc[base + 1] - obs_cyc[base]), 32'd4);
    check("t3_gap12", 32'(obs_cyc[base + 2] - obs_cyc[base + 1]), 32'd4);

    // Full buffer back-pressure
    flush_pulse();
    dc_ready = 1'b0;
    base = obs_n;
    push(32'h0000_3000, 1'b1);
    push(32'h0000_3040, 1'b1);
    push(32'h0000_3080, 1'b1);
    push(32'h0000_30C0, 1'b1);
    push(32'h0000_3100, 1'b1);
    smp(); check("t4_full_ready", pf_ready, 1'b0); check("t4_busy", busy, 1'b1);
    cyc();
    pf_valid = 1'b1; pf_req.addr = 32'h0000_3140;
    idle(2);
    smp(); check("t4_blocked", pf_ready, 1'b0); check("t4_no_hs", 32'(obs_n - base), 32'd0);
    cyc();
    dc_ready = 1'b1;
    n = 0;
    while (!pf_ready && n < 50) begin
      cyc();
      n++;
    end
    check("t4_ready_after_hs", pf_ready, 1'b1);
    check("t4_hs_before_accept", 32'(obs_n - base), 32'd1);
    exp_q.push_back(32'h0000_3140);
    cyc();
    pf_valid = 1'b0;
    wait_hs("t4", 60);

    // CPU demand holds off issue but never retracts a raised request
    flush_pulse();
    dc_ready = 1'b0;
    cpu_demand = 1'b1;
    push(32'h0000_2000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      smp(); check("t5_demand_hold", dc_valid, 1'b0);
      cyc();
    end
    cpu_demand = 1'b0;
    smp(); check("t5_low_cycle", dc_valid, 1'b0);
    cyc(); smp();
    check("t5_issue_valid", dc_valid, 1'b1);
    check("t5_issue_addr", dc_req.addr, 32'h0000_2000);
    cyc();
    cpu_demand = 1'b1;
    smp(); check("t5_no_retract", dc_valid, 1'b1);
    cyc();
    cpu_demand = 1'b0;
    dc_ready = 1'b1;
    wait_hs("t5", 10);

    // Filter eviction after FILTER_DEPTH+1 distinct lines
    flush_pulse();
    for (int i = 0; i < 9; i++) push(32'h0000_4000 + 32'(i) * 32'h40, 1'b1);
    wait_hs("t6_fill", 80);
    push(32'h0000_4080, 1'b0);
    push(32'h0000_4000, 1'b1);
    wait_hs("t6_reissue", 30);
    idle(10);
    drain("t6_tail");

    // Flush while a request is pending, and flush racing a push
    dc_ready = 1'b0;
    push(32'h0000_5000, 1'b0);
    cyc(); smp(); check("t7_req_valid", dc_valid, 1'b1);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    smp(); check("t7_flush_valid", dc_valid, 1'b0); check("t7_flush_busy", busy, 1'b0);
    cyc();
    flush = 1'b1; pf_valid = 1'b1; pf_req.addr = 32'h0000_6000;
    cyc();
    flush = 1'b0; pf_valid = 1'b0;
    smp(); check("t7_push_lost_busy", busy, 1'b0);
    cyc(); smp(); check("t7_push_lost_valid", dc_valid, 1'b0);
`ifdef HWPF_ISSUE_STATS_EN
    check("t7_stat_cleared", stat_issued, 32'd0);
`endif
    cyc();

    // Asynchronous reset in the middle of a request
    push(32'h0000_7000, 1'b0);
    cyc(); smp(); check("t8_req_valid", dc_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_valid", dc_valid, 1'b0);
    check("t8_rst_ready", pf_ready, 1'b1);
    check("t8_rst_busy", busy, 1'b0);
    check("t8_rst_addr", dc_req.addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(); smp(); check("t8_post_busy", busy, 1'b0); check("t8_post_valid", dc_valid, 1'b0);

    idle(5);
    drain("final");
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
